// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller around a 1-bit full-adder cell, LSB first; done pulses WIDTH+1 cycles after start.
// No backpressure: start is only taken in IDLE/DONE and ignored while busy. SERIAL_ADD_SUB_EN adds sub/ovf.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_final;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             accept;
  logic             last;
  logic             sub_sel;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last      = (state == SHIFT) && (cnt == LAST_CNT);
  assign res_final = {fa_sum, res_sh[WIDTH-1:1]};

  // The operand shifters zero-fill and the carry flop is cleared on the last
  // bit, so the cell feed is naturally 0 outside SHIFT with no gating.
  assign fa_a   = a_sh[0];
  assign fa_b   = b_sh[0];
  assign fa_cin = carry;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_sh   <= op_a;
      b_sh   <= sub_sel ? ~op_b : op_b;
      carry  <= sub_sel;
      res_sh <= '0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_final;
      cnt    <= cnt + 1'b1;
      if (last) begin
        // Result is captured here so it is already valid during the DONE cycle.
        carry     <= 1'b0;
        result    <= res_final;
        carry_out <= fa_cout;
      end else begin
        carry <= fa_cout;
      end
    end
  end

`ifdef SERIAL_ADD_SUB_EN
  // On the MSB bit the carry flop holds the carry into the MSB.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (last) begin
      ovf <= carry ^ fa_cout;
    end
  end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl with a behavioural full-adder cell and a result scoreboard.
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         o;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    exp_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         fa_sum;
  logic         fa_cout;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
  logic         ovf;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vecs[8];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
    .ovf       (ovf),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cin    (fa_cin),
    .fa_sum    (fa_sum),
    .fa_cout   (fa_cout)
  );

  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // glitch: SHIFT cycle index at which a stray start is pulsed (0 = none).
  // b2b: caller is sitting in a DONE cycle, so start is driven immediately.
  task automatic run_op(input vec_t v, input int glitch, input bit b2b);
    int           lat;
    int           busy_cnt;
    int           fa_bad;
    logic         c;
    logic [W-1:0] bb;
    exp_t         e;
    lat      = 0;
    busy_cnt = 0;
    fa_bad   = 0;
    c        = v.s;
    bb       = v.s ? ~v.b : v.b;
    sb.push_back(v.e);
    if (!b2b) @(negedge clk);
    op_a  = v.a;
    op_b  = v.b;
`ifdef SERIAL_ADD_SUB_EN
    sub   = v.s;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (busy) begin
        busy_cnt++;
        if (cyc <= W) begin
          if (fa_a !== v.a[cyc-1] || fa_b !== bb[cyc-1] || fa_cin !== c) fa_bad++;
          c = (v.a[cyc-1] & bb[cyc-1]) | (v.a[cyc-1] & c) | (bb[cyc-1] & c);
        end
      end
      if (done) begin
        lat = cyc;
        break;
      end
      if (glitch != 0 && cyc == glitch) begin
        op_a  = 8'h11;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("done_latency", lat, W + 1);
    chk("busy_cycles", busy_cnt, W);
    chk("fa_feed_errors", fa_bad, 0);
    chk("busy_in_done", busy, 1'b0);
    chk("fa_idle_in_done", {fa_a, fa_b, fa_cin}, 3'b000);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("result", result, e.res);
      chk("carry_out", carry_out, e.c);
`ifdef SERIAL_ADD_SUB_EN
      chk("ovf", ovf, e.o);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   done_seen;
    vec_t v;
`ifdef SERIAL_ADD_SUB_EN
    vec_t svecs[3];
    sub = 1'b0;
    svecs[0] = '{a: 8'h10, b: 8'h01, s: 1'b1, e: '{res: 8'h0F, c: 1'b1, o: 1'b0}};
    svecs[1] = '{a: 8'h80, b: 8'h01, s: 1'b1, e: '{res: 8'h7F, c: 1'b1, o: 1'b1}};
    svecs[2] = '{a: 8'h01, b: 8'h02, s: 1'b1, e: '{res: 8'hFF, c: 1'b0, o: 1'b0}};
`endif
    vecs[0] = '{a: 8'h5A, b: 8'h33, s: 1'b0, e: '{res: 8'h8D, c: 1'b0, o: 1'b1}};
    vecs[1] = '{a: 8'hFF, b: 8'h01, s: 1'b0, e: '{res: 8'h00, c: 1'b1, o: 1'b0}};
    vecs[2] = '{a: 8'h00, b: 8'h00, s: 1'b0, e: '{res: 8'h00, c: 1'b0, o: 1'b0}};
    vecs[3] = '{a: 8'h80, b: 8'h80, s: 1'b0, e: '{res: 8'h00, c: 1'b1, o: 1'b1}};
    vecs[4] = '{a: 8'h7F, b: 8'h01, s: 1'b0, e: '{res: 8'h80, c: 1'b0, o: 1'b1}};
    vecs[5] = '{a: 8'hAA, b: 8'h55, s: 1'b0, e: '{res: 8'hFF, c: 1'b0, o: 1'b0}};
    vecs[6] = '{a: 8'hFF, b: 8'hFF, s: 1'b0, e: '{res: 8'hFE, c: 1'b1, o: 1'b0}};
    vecs[7] = '{a: 8'h01, b: 8'h01, s: 1'b0, e: '{res: 8'h02, c: 1'b0, o: 1'b0}};

    reset_n = 1'b0;
    start   = 1'b0;
    op_a    = '0;
    op_b    = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_result", result, 8'h00);
    chk("reset_carry_out", carry_out, 1'b0);
    chk("reset_fa", {fa_a, fa_b, fa_cin}, 3'b000);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) run_op(vecs[i], 0, 1'b0);

    // Result must hold after done while idle.
    repeat (2) @(negedge clk);
    chk("hold_done_low", done, 1'b0);
    chk("hold_result", result, vecs[7].e.res);

    // Stray start mid-SHIFT with a different op_a must be ignored.
    run_op(vecs[0], 3, 1'b0);

    // Back-to-back: second start driven while the first is in DONE.
    run_op(vecs[1], 0, 1'b0);
    run_op(vecs[7], 0, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
    for (int i = 0; i < 3; i++) run_op(svecs[i], 0, 1'b0);
    sub = 1'b0;
`endif

    // Reset during the 4th SHIFT cycle aborts the add.
    @(negedge clk);
    op_a  = 8'hC3;
    op_b  = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 8'h00);
    chk("abort_carry_out", carry_out, 1'b0);
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);

    v = '{a: 8'h3C, b: 8'h0F, s: 1'b0, e: '{res: 8'h4B, c: 1'b0, o: 1'b0}};
    run_op(v, 0, 1'b0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
